// File: rtl/posl_adder_stream_ctrl.sv
// ============================================================================
// posl_adder_stream_ctrl
//
// Sequential wrapper around an external ripple-carry adder. Operands arrive
// D bits per beat (little-endian, beat k = bits [k*D+D-1:k*D]) on a
// valid/ready stream. Once W bits of both operands have been collected they
// are held on add_a/add_b/add_cin for SETTLE_CYC cycles. Then add_s/add_cout
// are captured and streamed back out D bits per beat. The block is
// half-duplex: LOAD -> SETTLE -> UNLOAD -> LOAD.
//
// Optional feature macro: POSL_ADDER_OVF_EN adds out_ovf, the two's-complement
// signed-overflow flag of the captured sum. It is valid on the last beat only.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input stream handshake
//   in_a, in_b [D]        operand words
//   in_cin                carry-in, sampled with the first beat only
//   add_a, add_b [W]      operands driven to the external adder
//   add_cin               carry-in driven to the external adder
//   add_s [W], add_cout   sum and carry returned by the external adder
//   out_valid/out_ready   output stream handshake
//   out_s [D]             sum word
//   out_cout              carry-out; nonzero only on the last beat
//   out_last              marks the final result beat
//   out_ovf               (POSL_ADDER_OVF_EN only) signed overflow, last beat
//
// W must be an integer multiple of D. SETTLE_CYC must be at least 1.
// ============================================================================
module posl_adder_stream_ctrl #(
   parameter int W          = 128,
   parameter int D          = 32,
   parameter int SETTLE_CYC = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [D-1:0] in_a,
   input  logic [D-1:0] in_b,
   input  logic         in_cin,
   output logic [W-1:0] add_a,
   output logic [W-1:0] add_b,
   output logic         add_cin,
   input  logic [W-1:0] add_s,
   input  logic         add_cout,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [D-1:0] out_s,
   output logic         out_cout,
`ifdef POSL_ADDER_OVF_EN
   output logic         out_ovf,
`endif
   output logic         out_last
);

   localparam int N  = W / D;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_UNLOAD = 2'd2
   } state_t;

   state_t          state_reg;
   logic [CW-1:0]   beat_reg;
   logic [SW-1:0]   settle_reg;
   logic [W-1:0]    a_reg;
   logic [W-1:0]    b_reg;
   logic            cin_reg;
   logic [W-1:0]    res_reg;
   logic            cout_reg;

   logic            in_ready_reg;
   logic            out_valid_reg;
   logic [D-1:0]    out_s_reg;
   logic            out_last_reg;
   logic            out_cout_reg;
`ifdef POSL_ADDER_OVF_EN
   logic            ovf_reg;
   logic            out_ovf_reg;
   logic            ovf_next;
`endif

   logic            beat_last;
   logic            settle_last;
   logic [CW-1:0]   beat_inc;
   logic            inc_is_last;

   assign beat_last   = (beat_reg == CW'(N - 1));
   assign settle_last = (settle_reg == SW'(SETTLE_CYC - 1));
   assign beat_inc    = beat_reg + CW'(1);
   assign inc_is_last = (beat_inc == CW'(N - 1));

`ifdef POSL_ADDER_OVF_EN
   // Same-sign operands producing a sum of the opposite sign.
   assign ovf_next = (a_reg[W-1] == b_reg[W-1]) && (add_s[W-1] != a_reg[W-1]);
`endif

   // The operand registers drive the adder directly, so partially loaded
   // values are visible during LOAD. Nothing is captured then, so this is
   // harmless.
   assign add_a   = a_reg;
   assign add_b   = b_reg;
   assign add_cin = cin_reg;

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign out_s     = out_s_reg;
   assign out_last  = out_last_reg;
   assign out_cout  = out_cout_reg;
`ifdef POSL_ADDER_OVF_EN
   assign out_ovf   = out_ovf_reg;
`endif

   // All stream outputs are registered. They are loaded one step ahead with
   // the value belonging to the beat that the next state will present.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_LOAD;
         beat_reg      <= '0;
         settle_reg    <= '0;
         a_reg         <= '0;
         b_reg         <= '0;
         cin_reg       <= 1'b0;
         res_reg       <= '0;
         cout_reg      <= 1'b0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         out_s_reg     <= '0;
         out_last_reg  <= 1'b0;
         out_cout_reg  <= 1'b0;
`ifdef POSL_ADDER_OVF_EN
         ovf_reg       <= 1'b0;
         out_ovf_reg   <= 1'b0;
`endif
      end else begin
         case (state_reg)
            ST_LOAD: begin
               // in_ready is 1 throughout LOAD, so in_valid alone marks a handshake.
               if (in_valid) begin
                  a_reg[int'(beat_reg)*D +: D] <= in_a;
                  b_reg[int'(beat_reg)*D +: D] <= in_b;
                  if (beat_reg == '0) begin
                     cin_reg <= in_cin;
                  end
                  if (beat_last) begin
                     beat_reg     <= '0;
                     settle_reg   <= '0;
                     in_ready_reg <= 1'b0;
                     state_reg    <= ST_SETTLE;
                  end else begin
                     beat_reg <= beat_inc;
                  end
               end
            end

            ST_SETTLE: begin
               if (settle_last) begin
                  // The adder output is taken as-is, with no logic in between.
                  res_reg       <= add_s;
                  cout_reg      <= add_cout;
                  settle_reg    <= '0;
                  out_valid_reg <= 1'b1;
                  out_s_reg     <= add_s[D-1:0];
                  out_last_reg  <= (N == 1);
                  out_cout_reg  <= (N == 1) ? add_cout : 1'b0;
`ifdef POSL_ADDER_OVF_EN
                  ovf_reg       <= ovf_next;
                  out_ovf_reg   <= (N == 1) ? ovf_next : 1'b0;
`endif
                  state_reg     <= ST_UNLOAD;
               end else begin
                  settle_reg <= settle_reg + SW'(1);
               end
            end

            ST_UNLOAD: begin
               // Without out_ready every output register simply holds.
               if (out_ready) begin
                  if (beat_last) begin
                     beat_reg      <= '0;
                     out_valid_reg <= 1'b0;
                     out_s_reg     <= '0;
                     out_last_reg  <= 1'b0;
                     out_cout_reg  <= 1'b0;
`ifdef POSL_ADDER_OVF_EN
                     out_ovf_reg   <= 1'b0;
`endif
                     in_ready_reg  <= 1'b1;
                     state_reg     <= ST_LOAD;
                  end else begin
                     beat_reg     <= beat_inc;
                     out_s_reg    <= res_reg[int'(beat_inc)*D +: D];
                     out_last_reg <= inc_is_last;
                     out_cout_reg <= inc_is_last ? cout_reg : 1'b0;
`ifdef POSL_ADDER_OVF_EN
                     out_ovf_reg  <= inc_is_last ? ovf_reg : 1'b0;
`endif
                  end
               end
            end

            default: begin
               state_reg     <= ST_LOAD;
               beat_reg      <= '0;
               in_ready_reg  <= 1'b1;
               out_valid_reg <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_posl_adder_stream_ctrl.sv
// ============================================================================
// tb_posl_adder_stream_ctrl
//
// Directed and random stimulus for posl_adder_stream_ctrl. The external adder
// is modelled behaviourally. Expected results come from plain W+1-bit
// arithmetic on the whole operands.
// ============================================================================
module tb_posl_adder_stream_ctrl;

   localparam int W = 128;
   localparam int D = 32;
   localparam int S = 4;
   localparam int N = W / D;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [D-1:0] in_a;
   logic [D-1:0] in_b;
   logic         in_cin;
   logic [W-1:0] add_a;
   logic [W-1:0] add_b;
   logic         add_cin;
   logic [W-1:0] add_s;
   logic         add_cout;
   logic         out_valid;
   logic         out_ready;
   logic [D-1:0] out_s;
   logic         out_cout;
   logic         out_last;
`ifdef POSL_ADDER_OVF_EN
   logic         out_ovf;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Behavioural stand-in for the external ripple-carry adder.
   assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

   posl_adder_stream_ctrl #(.W(W), .D(D), .SETTLE_CYC(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_s     (add_s),
      .add_cout  (add_cout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_s     (out_s),
      .out_cout  (out_cout),
`ifdef POSL_ADDER_OVF_EN
      .out_ovf   (out_ovf),
`endif
      .out_last  (out_last)
   );

   task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Send the first nbeats words of a/b. With gaps set, an idle beat carrying
   // junk data is inserted between handshakes. With hold set, in_valid stays
   // high with junk after the last beat.
   task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input int nbeats, input bit gaps, input bit hold);
      int g;
      for (int k = 0; k < nbeats; k++) begin
         if (gaps && k > 0) begin
            in_valid = 1'b0;
            in_a     = $urandom;
            in_b     = $urandom;
            in_cin   = ~cin;
            tick();
         end
         in_valid = 1'b1;
         in_a     = a[k*D +: D];
         in_b     = b[k*D +: D];
         in_cin   = (k == 0) ? cin : ~cin;
         g = 0;
         while (!in_ready && g < 200) begin
            tick();
            g++;
         end
         if (g >= 200) chk("in_ready_timeout", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
         tick();
      end
      in_valid = hold;
      in_a     = $urandom;
      in_b     = $urandom;
      in_cin   = $urandom;
   endtask

   // Collect one result and compare every beat with the reference sum.
   task automatic recv_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input int stall_beat, input int stall_len);
      logic [W:0]   exp_sum;
      logic         exp_ovf;
      logic [D-1:0] word;
      int           cnt;
      int           g;
      exp_sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      exp_ovf = (a[W-1] == b[W-1]) && (exp_sum[W-1] != a[W-1]);
      out_ready = 1'b1;
      chk({tag, "_add_a"}, {1'b0, add_a}, {1'b0, a});
      chk({tag, "_add_b"}, {1'b0, add_b}, {1'b0, b});
      chk({tag, "_add_cin"}, {{W{1'b0}}, add_cin}, {{W{1'b0}}, cin});
      cnt = 0;
      while (!out_valid && cnt < 200) begin
         chk({tag, "_settle_in_ready"}, {{W{1'b0}}, in_ready}, '0);
         chk({tag, "_settle_add_a"}, {1'b0, add_a}, {1'b0, a});
         tick();
         cnt++;
      end
      // The first output beat transfers on the edge after out_valid rises.
      chk({tag, "_latency"}, (W+1)'(cnt + 1), (W+1)'(S + 1));
      for (int k = 0; k < N; k++) begin
         g = 0;
         while (!out_valid && g < 200) begin
            tick();
            g++;
         end
         word = exp_sum[k*D +: D];
         chk($sformatf("%s_s%0d", tag, k), {{(W+1-D){1'b0}}, out_s}, {{(W+1-D){1'b0}}, word});
         chk($sformatf("%s_last%0d", tag, k), {{W{1'b0}}, out_last}, {{W{1'b0}}, (k == N-1)});
         chk($sformatf("%s_cout%0d", tag, k), {{W{1'b0}}, out_cout},
             {{W{1'b0}}, (k == N-1) ? exp_sum[W] : 1'b0});
`ifdef POSL_ADDER_OVF_EN
         chk($sformatf("%s_ovf%0d", tag, k), {{W{1'b0}}, out_ovf},
             {{W{1'b0}}, (k == N-1) ? exp_ovf : 1'b0});
`endif
         chk($sformatf("%s_in_ready%0d", tag, k), {{W{1'b0}}, in_ready}, '0);
         if (k == stall_beat && stall_len > 0) begin
            out_ready = 1'b0;
            for (int t = 0; t < stall_len; t++) begin
               tick();
               chk($sformatf("%s_stall_valid%0d", tag, t), {{W{1'b0}}, out_valid}, {{W{1'b0}}, 1'b1});
               chk($sformatf("%s_stall_s%0d", tag, t), {{(W+1-D){1'b0}}, out_s}, {{(W+1-D){1'b0}}, word});
               chk($sformatf("%s_stall_in_ready%0d", tag, t), {{W{1'b0}}, in_ready}, '0);
            end
            out_ready = 1'b1;
         end
         tick();
      end
      in_valid = 1'b0;
      chk({tag, "_done_in_ready"}, {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
      chk({tag, "_done_out_valid"}, {{W{1'b0}}, out_valid}, '0);
      $display("op %s a=%h b=%h cin=%0d sum=%h cout=%0d ovf=%0d", tag, a, b, cin,
               exp_sum[W-1:0], exp_sum[W], exp_ovf);
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input bit gaps, input bit hold,
                         input int stall_beat, input int stall_len);
      send_op(a, b, cin, N, gaps, hold);
      recv_op(tag, a, b, cin, stall_beat, stall_len);
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [W-1:0] all_ones;
      logic [W-1:0] max_pos;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_cin    = 1'b0;
      out_ready = 1'b0;
      all_ones  = '1;
      max_pos   = {1'b0, {(W-1){1'b1}}};

      // Reset state.
      #23;
      chk("rst_in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
      chk("rst_out_valid", {{W{1'b0}}, out_valid}, '0);
      chk("rst_out_s", {{(W+1-D){1'b0}}, out_s}, '0);
      chk("rst_out_last", {{W{1'b0}}, out_last}, '0);
      chk("rst_out_cout", {{W{1'b0}}, out_cout}, '0);
      chk("rst_add_a", {1'b0, add_a}, '0);
      chk("rst_add_b", {1'b0, add_b}, '0);
      chk("rst_add_cin", {{W{1'b0}}, add_cin}, '0);
`ifdef POSL_ADDER_OVF_EN
      chk("rst_out_ovf", {{W{1'b0}}, out_ovf}, '0);
`endif
      rst_n = 1'b1;
      tick();

      // 1: simple 1+1.
      run_op("one_plus_one", W'(1), W'(1), 1'b0, 1'b0, 1'b0, -1, 0);
      // 2: all-ones + 0 + carry wraps to zero with carry out.
      run_op("wrap", all_ones, '0, 1'b1, 1'b0, 1'b0, -1, 0);
      // 3: largest positive + 1 overflows the signed range.
      run_op("ovf", max_pos, W'(1), 1'b0, 1'b0, 1'b0, -1, 0);
      // 4: backpressure on beat 1 with in_valid held high throughout.
      run_op("bp", W'(1), W'(1), 1'b0, 1'b0, 1'b1, 1, 3);
      // 5: gaps between input beats.
      run_op("gaps", W'(1), W'(1), 1'b0, 1'b1, 1'b0, -1, 0);

      // 6: reset after two input beats, then a clean transaction.
      send_op({W{1'b1}}, {W{1'b1}}, 1'b1, 2, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
      chk("midrst_out_valid", {{W{1'b0}}, out_valid}, '0);
      chk("midrst_add_a", {1'b0, add_a}, '0);
      #2;
      rst_n = 1'b1;
      run_op("after_rst", W'(5), W'(3), 1'b0, 1'b0, 1'b0, -1, 0);

      // Random operands, carries, gaps and stalls.
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < N; k++) begin
            ra[k*D +: D] = $urandom;
            rb[k*D +: D] = $urandom;
         end
         run_op($sformatf("rnd%0d", r), ra, rb, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, N-1)), int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
